reset_teardown_seq: RTL and testbench

//   Orderly shutdown counterpart to the staged reset-release logic.
//   On a teardown request it asserts the three pipeline stage resets in the reverse
//   of their release order: stage 3, then stage 2, then stage 1.

---
 rtl/reset_teardown_seq_if.sv | 23 ++
 rtl/reset_teardown_seq.sv | 120 ++++++++++++
 tb/tb_reset_teardown_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/reset_teardown_seq_if.sv
// Handshake bundle between a teardown requester and reset_teardown_seq.
// The master drives the request and the stage idle flags; the slave returns the holds and status.
interface reset_teardown_seq_if;
  logic       req;
  logic [2:0] stage_idle;
  logic       hold_rst1;
  logic       hold_rst2;
  logic       hold_rst3;
  logic       busy;
  logic       ack;
  logic       timeout_err;
  logic [1:0] err_stage;

  modport master (
    output req, stage_idle,
    input  hold_rst1, hold_rst2, hold_rst3, busy, ack, timeout_err, err_stage
  );

  modport slave (
    input  req, stage_idle,
    output hold_rst1, hold_rst2, hold_rst3, busy, ack, timeout_err, err_stage
  );
endinterface

// File: rtl/reset_teardown_seq.sv
// Orderly pipeline shutdown: asserts stage resets 3, 2, 1 in turn, each after the
// stage drains (or a timeout forces it), with a fixed gap after every assertion.
module reset_teardown_seq #(
  parameter int GAP          = 10,
  parameter int IDLE_TIMEOUT = 255,
  parameter int CW           = 8
) (
  input  logic                 clk,
  input  logic                 ext_reset,
  reset_teardown_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, DRAIN3, GAP3, DRAIN2, GAP2, DRAIN1, GAP1, DONE
  } state_t;

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(IDLE_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    hold;
  logic          busy;
  logic          ack;
  logic          timeout_err;
  logic [1:0]    err_stage;

  // Per-state decode: which stage is being handled and where it goes next.
  logic [1:0] stage_k;
  logic [2:0] stage_sel;
  state_t     next_gap;
  state_t     next_drain;
  logic       stage_ready;

  always_comb begin
    stage_k    = 2'd0;
    stage_sel  = 3'b000;
    next_gap   = IDLE;
    next_drain = DONE;
    case (state)
      DRAIN3:  begin stage_k = 2'd3; stage_sel = 3'b100; next_gap = GAP3; end
      GAP3:    begin stage_k = 2'd3; stage_sel = 3'b100; next_drain = DRAIN2; end
      DRAIN2:  begin stage_k = 2'd2; stage_sel = 3'b010; next_gap = GAP2; end
      GAP2:    begin stage_k = 2'd2; stage_sel = 3'b010; next_drain = DRAIN1; end
      DRAIN1:  begin stage_k = 2'd1; stage_sel = 3'b001; next_gap = GAP1; end
      GAP1:    begin stage_k = 2'd1; stage_sel = 3'b001; next_drain = DONE; end
      default: begin stage_k = 2'd0; end
    endcase
  end

  assign stage_ready = |(bus.stage_idle & stage_sel);

  always_ff @(posedge clk or posedge ext_reset) begin
    if (ext_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hold        <= 3'b000;
      busy        <= 1'b0;
      ack         <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            state <= DRAIN3;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DRAIN3, DRAIN2, DRAIN1: begin
          if (stage_ready || cnt == TO_LAST) begin
            hold  <= hold | stage_sel;
            cnt   <= '0;
            state <= next_gap;
            // Idle wins over timeout when both land on the same edge.
            if (!stage_ready) begin
              timeout_err <= 1'b1;
              if (err_stage == 2'd0) err_stage <= stage_k;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP3, GAP2, GAP1: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= next_drain;
            if (state == GAP1) begin
              busy <= 1'b0;
              ack  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    assert (GAP >= 1 && GAP <= (1 << CW) && IDLE_TIMEOUT >= 1 && IDLE_TIMEOUT <= (1 << CW))
      else $error("reset_teardown_seq: GAP/IDLE_TIMEOUT out of range for CW");
  end

  assign bus.hold_rst1   = hold[0];
  assign bus.hold_rst2   = hold[1];
  assign bus.hold_rst3   = hold[2];
  assign bus.busy        = busy;
  assign bus.ack         = ack;
  assign bus.timeout_err = timeout_err;
  assign bus.err_stage   = err_stage;

endmodule

// File: tb/tb_reset_teardown_seq.sv
// Randomized bench for reset_teardown_seq; expected output timelines are derived
// from per-stage drain delays with plain edge arithmetic.
module tb_reset_teardown_seq;
  localparam int G     = 10;
  localparam int T     = 255;
  localparam int STUCK = 100000;

  logic clk;
  logic ext_reset;
  reset_teardown_seq_if bus ();

  reset_teardown_seq #(.GAP(G), .IDLE_TIMEOUT(T), .CW(8)) dut (
    .clk       (clk),
    .ext_reset (ext_reset),
    .bus       (bus)
  );

  int total_count = 0;
  int pass_count  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_count++;
    if (got !== exp)
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    else
      pass_count++;
  endtask

  task automatic check_all(input string ph, input int h3, input int h2, input int h1,
                           input int bsy, input int ak, input int te, input int es);
    check({ph, ".hold_rst3"},   32'(bus.hold_rst3),   32'(h3));
    check({ph, ".hold_rst2"},   32'(bus.hold_rst2),   32'(h2));
    check({ph, ".hold_rst1"},   32'(bus.hold_rst1),   32'(h1));
    check({ph, ".busy"},        32'(bus.busy),        32'(bsy));
    check({ph, ".ack"},         32'(bus.ack),         32'(ak));
    check({ph, ".timeout_err"}, 32'(bus.timeout_err), 32'(te));
    check({ph, ".err_stage"},   32'(bus.err_stage),   32'(es));
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 3) return 0;
    if (r <= 6) return $urandom_range(1, 20);
    if (r <= 8) return T - 2 + $urandom_range(0, 3);
    return STUCK;
  endfunction

  // d[k] = number of DRAINk edges that see stage k busy before it reports idle.
  task automatic run_trial(input int tid, input int d3, input int d2, input int d1, input int abort_n);
    int d[1:3], dur[1:3], start[1:3], rise[1:3];
    int ack_e, err_e, err_k, last_n;
    bit to[1:3];
    d[3] = d3; d[2] = d2; d[1] = d1;
    for (int k = 1; k <= 3; k++) begin
      to[k]  = (d[k] >= T);
      dur[k] = to[k] ? T : d[k] + 1;
    end
    start[3] = 0;
    rise[3]  = start[3] + dur[3];
    start[2] = rise[3] + G;
    rise[2]  = start[2] + dur[2];
    start[1] = rise[2] + G;
    rise[1]  = start[1] + dur[1];
    ack_e    = rise[1] + G;
    err_e = -1; err_k = 0;
    for (int k = 3; k >= 1; k--)
      if (to[k] && err_k == 0) begin err_k = k; err_e = rise[k]; end

    $display("trial %0d: delays s3=%0d s2=%0d s1=%0d abort=%0d rises=%0d/%0d/%0d ack=%0d err_stage=%0d",
             tid, d3, d2, d1, abort_n, rise[3], rise[2], rise[1], ack_e, err_k);

    @(negedge clk);
    check_all("idle", 0, 0, 0, 0, 0, 0, 0);
    bus.req        = 1'b1;
    bus.stage_idle = 3'($urandom);
    last_n = ack_e + 4;
    for (int n = 0; n <= last_n; n++) begin
      if (n > 0) begin
        @(negedge clk);
        bus.req = (n >= ack_e) ? 1'b1 : 1'($urandom);
        for (int k = 1; k <= 3; k++) begin
          if (n > start[k] && n <= rise[k])
            bus.stage_idle[k-1] = (n - start[k] >= d[k] + 1);
          else
            bus.stage_idle[k-1] = 1'($urandom);
        end
      end
      @(posedge clk);
      #1;
      check_all("seq", int'(n >= rise[3]), int'(n >= rise[2]), int'(n >= rise[1]),
                int'(n < ack_e), int'(n >= ack_e),
                int'(err_e >= 0 && n >= err_e), (err_e >= 0 && n >= err_e) ? err_k : 0);
      if (n == abort_n) begin
        #2 ext_reset = 1'b1;
        #1 check_all("abort", 0, 0, 0, 0, 0, 0, 0);
        break;
      end
    end
    @(negedge clk);
    ext_reset = 1'b1;
    bus.req   = 1'b0;
    #1 check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    ext_reset = 1'b0;
  endtask

  initial begin
    int ab;
    int a, b, c;
    ext_reset      = 1'b1;
    bus.req        = 1'b0;
    bus.stage_idle = 3'b000;
    #1 check_all("por", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    ext_reset = 1'b0;

    run_trial(0, 0, 0, 0, -1);
    run_trial(1, 0, 5, 0, -1);
    run_trial(2, 0, STUCK, 0, -1);
    run_trial(3, 0, 0, 0, 2 * G + 5);
    run_trial(4, STUCK, 0, STUCK, -1);
    run_trial(5, 0, T - 1, T - 2, -1);
    for (int i = 6; i < 22; i++) begin
      a = pick_delay(); b = pick_delay(); c = pick_delay();
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * G + 30) : -1;
      run_trial(i, a, b, c, ab);
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_count, total_count);
    $fatal(1, "watchdog");
  end
endmodule
